column_scheduler: RTL

- Drains the per-column info/data FIFOs filled by the h2c partition stage into one shared processing engine, one column at a time in ascending column order.
- Starts a job on the partition-done pulse and streams each column's data beats with a column tag and a last-beat marker.
- Pulses process_done after the last active column has been drained, which releases the partition stage for the next transfer.

---
 rtl/column_scheduler_pkg.sv | 29 ++
 rtl/column_scheduler_col_prio_sel.sv | 30 +++
 rtl/column_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/column_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : column_scheduler_pkg
// Brief    : State encoding, info-header field layout and beat-count helper.
// Revision : 1.0
// ============================================================================
package column_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5
  } sched_state_e;

  localparam int LEN_W      = 16;
  localparam int BEAT_SHIFT = 4;
  localparam int BEAT_CNT_W = LEN_W - BEAT_SHIFT + 1;

  // 16-byte beats, rounding a partial trailing beat up.
  function automatic logic [BEAT_CNT_W-1:0] beat_count(input logic [LEN_W-1:0] len);
    beat_count = {1'b0, len[LEN_W-1:BEAT_SHIFT]}
               + BEAT_CNT_W'(len[BEAT_SHIFT-1:0] != '0);
  endfunction

endpackage : column_scheduler_pkg
`default_nettype wire

// File: rtl/column_scheduler_col_prio_sel.sv
`default_nettype none
// ============================================================================
// Module   : column_scheduler_col_prio_sel
// Brief    : Lowest set mask bit at or above a pointer, as one-hot plus valid.
// Revision : 1.0
// ============================================================================
module column_scheduler_col_prio_sel #(
  parameter int N     = 4,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic             valid
);

  logic [N-1:0] eligible;

  generate
    for (genvar g = 0; g < N; g++) begin : g_elig
      assign eligible[g] = mask[g] && (PTR_W'(g) >= ptr);
    end
  endgenerate

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = eligible & (~eligible + N'(1));
  assign valid  = |eligible;

endmodule : column_scheduler_col_prio_sel
`default_nettype wire

// File: rtl/column_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : column_scheduler
// Brief    : Drains per-column info/data FWFT FIFOs into one engine, in order.
// Revision : 1.0
// ============================================================================
module column_scheduler
  import column_scheduler_pkg::*;
#(
  parameter int TCQ          = 1,
  parameter int DATA_WIDTH   = 128,
  parameter int COL_MAX_SIZE = 4,
  parameter int LEN_LSB      = 112
) (
  input  logic                               user_clk,
  input  logic                               user_rst,
  input  logic                               partition_done,
  output logic                               process_done,
  output logic                               busy,
  input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] info_fifo_dout,
  input  logic [COL_MAX_SIZE-1:0]            info_fifo_empty,
  output logic [COL_MAX_SIZE-1:0]            info_fifo_rd_en,
  input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] data_fifo_dout,
  input  logic [COL_MAX_SIZE-1:0]            data_fifo_empty,
  output logic [COL_MAX_SIZE-1:0]            data_fifo_rd_en,
  output logic [DATA_WIDTH-1:0]              eng_tdata,
  output logic                               eng_tvalid,
  input  logic                               eng_tready,
  output logic                               eng_tlast,
  output logic [COL_MAX_SIZE-1:0]            eng_col
);

  localparam int IDX_W = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;
  localparam int PTR_W = $clog2(COL_MAX_SIZE + 1);

  sched_state_e            state_q, state_d;
  logic [COL_MAX_SIZE-1:0] mask_q, mask_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        col_q, col_d;
  logic [BEAT_CNT_W-1:0]   count_q, count_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [COL_MAX_SIZE-1:0] sel_onehot;
  logic                    sel_valid;
  logic [IDX_W-1:0]        sel_idx;
  logic [DATA_WIDTH-1:0]   info_head;
  logic [DATA_WIDTH-1:0]   data_head;
  logic [BEAT_CNT_W-1:0]   hdr_beats;
  logic                    unused_bits;

  column_scheduler_col_prio_sel #(
    .N     (COL_MAX_SIZE),
    .PTR_W (PTR_W)
  ) u_col_prio_sel (
    .mask   (mask_q),
    .ptr    (ptr_q),
    .onehot (sel_onehot),
    .valid  (sel_valid)
  );

  always_comb begin
    sel_idx   = '0;
    info_head = '0;
    data_head = '0;
    for (int i = 0; i < COL_MAX_SIZE; i++) begin
      if (sel_onehot[i]) sel_idx = IDX_W'(i);
      if (IDX_W'(i) == col_q) begin
        info_head = info_fifo_dout[i*DATA_WIDTH +: DATA_WIDTH];
        data_head = data_fifo_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign hdr_beats   = beat_count(info_head[LEN_LSB +: LEN_W]);
  // Only the length field of the info head is consumed.
  assign unused_bits = ^{info_head, 32'(TCQ)};

  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    ptr_d           = ptr_q;
    col_d           = col_q;
    count_d         = count_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    info_fifo_rd_en = '0;
    data_fifo_rd_en = '0;
    eng_tdata       = '0;
    eng_tvalid      = 1'b0;
    eng_tlast       = 1'b0;
    eng_col         = '0;

    case (state_q)
      ST_IDLE: begin
        if (partition_done) begin
          mask_d  = ~info_fifo_empty;
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (sel_valid) begin
          col_d   = sel_idx;
          state_d = ST_HDR;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_HDR: begin
        if (!info_fifo_empty[col_q]) begin
          info_fifo_rd_en[col_q] = 1'b1;
          count_d                = hdr_beats;
          state_d                = (hdr_beats == '0) ? ST_NEXT : ST_DATA;
        end
      end
      ST_DATA: begin
        eng_col[col_q] = 1'b1;
        eng_tdata      = data_head;
        eng_tvalid     = !data_fifo_empty[col_q];
        eng_tlast      = eng_tvalid && (count_q == BEAT_CNT_W'(1));
        if (eng_tvalid && eng_tready) begin
          data_fifo_rd_en[col_q] = 1'b1;
          count_d                = count_q - BEAT_CNT_W'(1);
          if (count_q == BEAT_CNT_W'(1)) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        mask_d[col_q] = 1'b0;
        ptr_d         = PTR_W'(col_q) + PTR_W'(1);
        state_d       = ST_SCAN;
      end
      ST_DONE: begin
        // Registered so busy falls on the same edge process_done rises.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst) begin
    if (!user_rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy         = busy_q;
  assign process_done = done_q;

endmodule : column_scheduler
`default_nettype wire
